// File: rtl/sid_pkg.sv
// Shared register map and sizing constants for the SID-compatible bus responder.
package sid_pkg;

  localparam int VOICE_COUNT           = 3;
  localparam int VOICE_STRIDE          = 7;
  localparam int DECAY_STROBES_DEFAULT = 2000;
  localparam int DECAY_W_DEFAULT       = 11;

  typedef enum logic [2:0] {
    VREG_FREQ_LO = 3'd0,
    VREG_FREQ_HI = 3'd1,
    VREG_PW_LO   = 3'd2,
    VREG_PW_HI   = 3'd3,
    VREG_CTRL    = 3'd4,
    VREG_AD      = 3'd5,
    VREG_SR      = 3'd6
  } voice_reg_e;

  localparam logic [4:0] ADDR_V1_FREQ_LO = 5'd0;
  localparam logic [4:0] ADDR_V1_FREQ_HI = 5'd1;
  localparam logic [4:0] ADDR_V1_PW_LO   = 5'd2;
  localparam logic [4:0] ADDR_V1_PW_HI   = 5'd3;
  localparam logic [4:0] ADDR_V1_CTRL    = 5'd4;
  localparam logic [4:0] ADDR_V1_AD      = 5'd5;
  localparam logic [4:0] ADDR_V1_SR      = 5'd6;
  localparam logic [4:0] ADDR_V2_FREQ_LO = 5'd7;
  localparam logic [4:0] ADDR_V2_FREQ_HI = 5'd8;
  localparam logic [4:0] ADDR_V2_PW_LO   = 5'd9;
  localparam logic [4:0] ADDR_V2_PW_HI   = 5'd10;
  localparam logic [4:0] ADDR_V2_CTRL    = 5'd11;
  localparam logic [4:0] ADDR_V2_AD      = 5'd12;
  localparam logic [4:0] ADDR_V2_SR      = 5'd13;
  localparam logic [4:0] ADDR_V3_FREQ_LO = 5'd14;
  localparam logic [4:0] ADDR_V3_FREQ_HI = 5'd15;
  localparam logic [4:0] ADDR_V3_PW_LO   = 5'd16;
  localparam logic [4:0] ADDR_V3_PW_HI   = 5'd17;
  localparam logic [4:0] ADDR_V3_CTRL    = 5'd18;
  localparam logic [4:0] ADDR_V3_AD      = 5'd19;
  localparam logic [4:0] ADDR_V3_SR      = 5'd20;
  localparam logic [4:0] ADDR_FC_LO      = 5'd21;
  localparam logic [4:0] ADDR_FC_HI      = 5'd22;
  localparam logic [4:0] ADDR_RES_FILT   = 5'd23;
  localparam logic [4:0] ADDR_MODE_VOL   = 5'd24;
  localparam logic [4:0] ADDR_POTX       = 5'd25;
  localparam logic [4:0] ADDR_POTY       = 5'd26;
  localparam logic [4:0] ADDR_OSC3       = 5'd27;
  localparam logic [4:0] ADDR_ENV3       = 5'd28;

  function automatic logic [4:0] voice_addr(input int voice, input voice_reg_e reg_sel);
    return 5'(voice * VOICE_STRIDE + int'(reg_sel));
  endfunction

endpackage

// File: rtl/sid_open_bus.sv
// Open-bus latch: holds the last value seen on the data bus and fades it to zero
// after a fixed number of bus strobes without a fresh load.
module sid_open_bus
  import sid_pkg::*;
#(
  parameter int DECAY_STROBES = DECAY_STROBES_DEFAULT,
  parameter int DECAY_W       = DECAY_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       strobe,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] value
);

  logic [DECAY_W-1:0] count;

  // A load always wins over expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      value <= load_value;
      count <= DECAY_W'(DECAY_STROBES);
    end else if (strobe && count != '0) begin
      count <= count - DECAY_W'(1);
      if (count == DECAY_W'(1)) begin
        value <= '0;
      end
    end
  end

endmodule

// File: rtl/sid_bus_regs.sv
// SID bus responder: write-only voice/filter/volume register file, gate-edge
// pulses for the envelope generators, and readback with open-bus decay.
module sid_bus_regs
  import sid_pkg::*;
#(
  parameter int DECAY_STROBES = DECAY_STROBES_DEFAULT,
  parameter int DECAY_W       = DECAY_W_DEFAULT
) (
  input  logic        clk8_i,
  input  logic        reset_i,
  input  logic        cpu_en_i,
  input  logic        rw_ni,
  input  logic [4:0]  addr_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        data_oe_o,
  input  logic [7:0]  osc3_i,
  input  logic [7:0]  env3_i,
  input  logic [7:0]  potx_i,
  input  logic [7:0]  poty_i,
  output logic [47:0] freq_o,
  output logic [35:0] pw_o,
  output logic [23:0] ctrl_o,
  output logic [23:0] ad_o,
  output logic [23:0] sr_o,
  output logic [10:0] fc_o,
  output logic [7:0]  res_filt_o,
  output logic [7:0]  mode_vol_o,
  output logic [2:0]  gate_on_o,
  output logic [2:0]  gate_off_o
);

  logic [2:0][15:0] freq;
  logic [2:0][11:0] pw;
  logic [2:0][7:0]  ctrl;
  logic [2:0][7:0]  ad;
  logic [2:0][7:0]  sr;
  logic [10:0]      fc;
  logic [7:0]       res_filt;
  logic [7:0]       mode_vol;
  logic [2:0]       gate_on;
  logic [2:0]       gate_off;

  logic       wr_en;
  logic       rd_en;
  logic       rd_live;
  logic [7:0] rd_value;
  logic [7:0] latch;

  assign wr_en     = cpu_en_i & ~rw_ni;
  assign rd_en     = cpu_en_i & rw_ni;
  assign data_oe_o = rd_en;

  always_ff @(posedge clk8_i) begin
    if (reset_i) begin
      freq     <= '0;
      pw       <= '0;
      ctrl     <= '0;
      ad       <= '0;
      sr       <= '0;
      fc       <= '0;
      res_filt <= '0;
      mode_vol <= '0;
      gate_on  <= '0;
      gate_off <= '0;
    end else begin
      gate_on  <= '0;
      gate_off <= '0;
      if (wr_en) begin
        for (int n = 0; n < VOICE_COUNT; n++) begin
          if (addr_i == voice_addr(n, VREG_FREQ_LO)) freq[n][7:0]  <= data_i;
          if (addr_i == voice_addr(n, VREG_FREQ_HI)) freq[n][15:8] <= data_i;
          if (addr_i == voice_addr(n, VREG_PW_LO))   pw[n][7:0]    <= data_i;
          if (addr_i == voice_addr(n, VREG_PW_HI))   pw[n][11:8]   <= data_i[3:0];
          if (addr_i == voice_addr(n, VREG_AD))      ad[n]         <= data_i;
          if (addr_i == voice_addr(n, VREG_SR))      sr[n]         <= data_i;
          // Pulse lines up with the cycle the new ctrl value first appears.
          if (addr_i == voice_addr(n, VREG_CTRL)) begin
            ctrl[n]     <= data_i;
            gate_on[n]  <= data_i[0] & ~ctrl[n][0];
            gate_off[n] <= ~data_i[0] & ctrl[n][0];
          end
        end
        case (addr_i)
          ADDR_FC_LO:    fc[2:0]  <= data_i[2:0];
          ADDR_FC_HI:    fc[10:3] <= data_i;
          ADDR_RES_FILT: res_filt <= data_i;
          ADDR_MODE_VOL: mode_vol <= data_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_value = latch;
    rd_live  = 1'b0;
    case (addr_i)
      ADDR_POTX: begin rd_value = potx_i; rd_live = 1'b1; end
      ADDR_POTY: begin rd_value = poty_i; rd_live = 1'b1; end
      ADDR_OSC3: begin rd_value = osc3_i; rd_live = 1'b1; end
      ADDR_ENV3: begin rd_value = env3_i; rd_live = 1'b1; end
      default: ;
    endcase
  end

  assign data_o = rd_value;

  sid_open_bus #(
    .DECAY_STROBES(DECAY_STROBES),
    .DECAY_W      (DECAY_W)
  ) u_open_bus (
    .clk       (clk8_i),
    .reset     (reset_i),
    .strobe    (cpu_en_i),
    .load      (wr_en | (rd_en & rd_live)),
    .load_value(wr_en ? data_i : rd_value),
    .value     (latch)
  );

  assign freq_o     = freq;
  assign pw_o       = pw;
  assign ctrl_o     = ctrl;
  assign ad_o       = ad;
  assign sr_o       = sr;
  assign fc_o       = fc;
  assign res_filt_o = res_filt;
  assign mode_vol_o = mode_vol;
  assign gate_on_o  = gate_on;
  assign gate_off_o = gate_off;

endmodule

// File: doc/sid_bus_regs.md
Name: sid_bus_regs

Overview:
- Bus-responder half of the SID-compatible audio block.
- Accepts CPU register writes and reads on the 5-bit SID bus.
- Holds every write-only voice, filter and volume register, and generates one-cycle gate-edge pulses for the envelope generators.
- Serves reads of the readback registers (POTX, POTY, OSC3, ENV3) and models SID open-bus decay for the write-only addresses.

Parameters:
- DECAY_STROBES, 2000: number of cpu_en_i strobes after the last bus access before the open-bus latch clears to 8'h00.
- DECAY_W, 11: width of the decay counter; must satisfy 2**DECAY_W > DECAY_STROBES.

Ports:
- clk8_i  in  1  8 MHz strobe clock; all state changes on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- cpu_en_i  in  1  bus-cycle enable; one clk8_i cycle per CPU cycle.
- rw_ni  in  1  1 = read, 0 = write.
- addr_i  in  5  SID register address 0..31.
- data_i  in  8  write data.
- data_o  out  8  read data.
- data_oe_o  out  1  read-data valid, equal to cpu_en_i & rw_ni.
- osc3_i  in  8  voice-3 oscillator upper bits (live).
- env3_i  in  8  voice-3 envelope level (live).
- potx_i  in  8  paddle X value.
- poty_i  in  8  paddle Y value.
- freq_o  out  48  voice frequencies {v3,v2,v1}, 16 bits each.
- pw_o  out  36  pulse widths {v3,v2,v1}, 12 bits each.
- ctrl_o  out  24  control registers {v3,v2,v1}.
- ad_o  out  24  attack/decay registers {v3,v2,v1}.
- sr_o  out  24  sustain/release registers {v3,v2,v1}.
- fc_o  out  11  filter cutoff.
- res_filt_o  out  8  resonance / filter routing.
- mode_vol_o  out  8  filter mode / master volume.
- gate_on_o  out  3  one-cycle pulse per voice on a gate 0→1 transition.
- gate_off_o  out  3  one-cycle pulse per voice on a gate 1→0 transition.

Behaviour:
- Reset (synchronous, active-high): every register output, the open-bus latch, the decay counter, gate_on_o and gate_off_o are all 0.
- Reset has priority over a concurrent write.
- Write condition: cpu_en_i & ~rw_ni at a rising clk8_i edge. The addressed register updates on that edge, so the new value is visible the following cycle. Writes take exactly one cycle.
- Address map, voice n (n = 0..2, base 7n):
  - base+0: freq lo; base+1: freq hi.
  - base+2: pw lo; base+3[3:0]: pw hi, bits [7:4] ignored.
  - base+4: ctrl; base+5: ad; base+6: sr.
- Address map, filter and volume:
  - 21[2:0] → fc_o[2:0]; 22 → fc_o[10:3].
  - 23: res_filt; 24: mode_vol.
  - 25..31: writes do not change any register; they still load the latch.
- Gate pulses:
  - A write to ctrl (address 4, 11 or 18) whose new bit0 differs from the old bit0 pulses gate_on_o[n] (new = 1) or gate_off_o[n] (new = 0).
  - The pulse is high for exactly the cycle the new ctrl value first appears.
  - Rewriting the same gate value produces no pulse.
- Reads (combinational mux of registered state, valid while data_oe_o is high):
  - 25 → potx_i; 26 → poty_i; 27 → osc3_i; 28 → env3_i.
  - All other addresses → open-bus latch.
- Open-bus latch:
  - Loaded with data_i on every write, and with the returned value on every read of 25..28.
  - Each such load sets the counter to DECAY_STROBES.
  - Each cpu_en_i strobe with no load decrements the counter, saturating at 0.
  - On the strobe where the counter goes 1→0, the latch clears to 0.
  - A load in the same cycle as expiry wins: the latch reloads and the counter is set to DECAY_STROBES.
- Reads never modify voice or filter registers.

Decomposition:
- Shared package sid_pkg:
  - Register address constants (ADDR_V1_FREQ_LO … ADDR_ENV3).
  - Voice stride 7, voice count 3.
  - Default decay constant.
- One sub-module, sid_open_bus: owns the latch and the decay counter; inputs are load, load_value and strobe. sid_bus_regs holds the register file and the gate-edge logic.

Test Plan:
- Reset, then read address 0 → data_o = 8'h00; all outputs 0, no gate pulses.
- Write addr 0 = 8'h34, addr 1 = 8'h12 → freq_o[15:0] = 16'h1234 one cycle after the second write; freq_o[47:16] unchanged.
- Write addr 4 = 8'h11, then 8'h11 again, then 8'h10 → gate_on_o[0] pulses once for one clk8_i cycle, no pulse on the repeat, then gate_off_o[0] pulses once.
- Write addr 24 = 8'h1F, then read addr 24 → returns 8'h1F. After DECAY_STROBES idle strobes (set to 4 in this test), the read returns 8'h00 on the 4th strobe, not before.
- Drive osc3_i = 8'hA5 and read addr 27 → data_o = 8'hA5. A subsequent read of addr 30 returns 8'hA5 from the latch.
- Assert reset_i in the same cycle as a write to addr 22 = 8'hFF → fc_o stays 0 and no latch load occurs.
